// File: rtl/mvau_stream_out_buffer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : mvau_stream_out_buffer
// Purpose  : Output buffer behind the MVAU PE array/accumulators. Each completed
//            PE-wide accumulation pulse is captured into a small FIFO and
//            presented on a valid/ready stream. wait_rready tells the stream
//            control block that the head word is stalled, so it can halt
//            computation before this buffer overflows.
// Ports    : aclk, areset (sync, active-high)
//            in_v, in_data[PE*TA]      - accumulated word from PE array
//            rready                    - downstream ready
//            out_v, out_data[PE*TA]    - head of FIFO
//            wait_rready               - out_v & ~rready
//            full, count[DEPTH_T+1]    - occupancy status
//            ovf (only with MVAU_OUT_OVF_DET_EN) - sticky dropped-word flag
// Config   : define MVAU_OUT_OVF_DET_EN to add the ovf port and a drop assertion.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module mvau_stream_out_buffer #(
    parameter int PE      = 2,
    parameter int TA      = 16,
    parameter int DEPTH   = 2,
    parameter int DEPTH_T = 1
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 in_v,
    input  logic [PE*TA-1:0]     in_data,
    input  logic                 rready,
    output logic                 out_v,
    output logic [PE*TA-1:0]     out_data,
    output logic                 wait_rready,
    output logic                 full,
`ifdef MVAU_OUT_OVF_DET_EN
    output logic                 ovf,
`endif
    output logic [DEPTH_T:0]     count
);

    localparam int               c_W     = PE * TA;
    localparam logic [DEPTH_T:0] c_DEPTH = DEPTH[DEPTH_T:0];

    // Storage and pointers; pointers wrap naturally at DEPTH_T bits.
    logic [c_W-1:0]     r_mem_q [DEPTH];
    logic [c_W-1:0]     w_mem_d [DEPTH];
    logic [DEPTH_T-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [DEPTH_T-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [DEPTH_T:0]   r_count_q,  w_count_d;

    logic w_push;
    logic w_pop;
    logic w_drop;

    // Status outputs come straight from registered occupancy, so out_data
    // has no combinational path from in_data.
    assign out_v       = (r_count_q != '0);
    assign full        = (r_count_q == c_DEPTH);
    assign count       = r_count_q;
    assign out_data    = r_mem_q[r_rd_ptr_q];
    assign wait_rready = out_v & ~rready;

    // A push is allowed into a full FIFO only when the head leaves the same cycle.
    assign w_pop  = out_v & rready;
    assign w_push = in_v & (~full | w_pop);
    assign w_drop = in_v & full & ~w_pop;

    always_comb begin
        w_mem_d    = r_mem_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_push) begin
            w_mem_d[r_wr_ptr_q] = in_data;
            w_wr_ptr_d          = r_wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end
        // Push and pop together leave the occupancy unchanged.
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
            r_mem_q    <= w_mem_d;
        end
    end

`ifdef MVAU_OUT_OVF_DET_EN
    // Sticky overflow flag: a dropped word means the control block broke
    // its halt contract; only reset clears the evidence.
    logic r_ovf_q, w_ovf_d;

    always_comb begin
        w_ovf_d = r_ovf_q | w_drop;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_ovf_q <= 1'b0;
        end else begin
            r_ovf_q <= w_ovf_d;
            assert (!w_drop);
        end
    end

    assign ovf = r_ovf_q;
`else
    // Without detection, dropped words are silently discarded.
    logic w_drop_unused;
    assign w_drop_unused = w_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mvau_stream_out_buffer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_mvau_stream_out_buffer
// Purpose  : Self-checking bench for mvau_stream_out_buffer. A queue-based
//            reference FIFO predicts each delivered word; a negedge monitor
//            compares every handshake against the expected queue.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mvau_stream_out_buffer;

    localparam int PE      = 2;
    localparam int TA      = 16;
    localparam int DEPTH   = 2;
    localparam int DEPTH_T = 1;
    localparam int W       = PE * TA;

    logic             clk = 1'b0;
    logic             areset;
    logic             in_v;
    logic [W-1:0]     in_data;
    logic             rready;
    logic             out_v;
    logic [W-1:0]     out_data;
    logic             wait_rready;
    logic             full;
    logic [DEPTH_T:0] count;
`ifdef MVAU_OUT_OVF_DET_EN
    logic             ovf;
`endif

    mvau_stream_out_buffer #(
        .PE      (PE),
        .TA      (TA),
        .DEPTH   (DEPTH),
        .DEPTH_T (DEPTH_T)
    ) dut (
        .aclk        (clk),
        .areset      (areset),
        .in_v        (in_v),
        .in_data     (in_data),
        .rready      (rready),
        .out_v       (out_v),
        .out_data    (out_data),
        .wait_rready (wait_rready),
        .full        (full),
`ifdef MVAU_OUT_OVF_DET_EN
        .ovf         (ovf),
`endif
        .count       (count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: the FIFO as a plain queue with a capacity limit.
    logic [W-1:0] exp_q [$];
    int           m_count = 0;
    bit           m_ovf   = 1'b0;

    // Stability tracking for the monitor.
    bit           hold_prev = 1'b0;
    logic [W-1:0] hold_data = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every accepted word must match the head of the expected queue,
    // and a stalled word must not change or disappear.
    always @(negedge clk) begin
        if (areset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", {{(W-1){1'b0}}, out_v}, {{(W-1){1'b0}}, 1'b1});
                check("hold_data", out_data, hold_data);
            end
            if (out_v && rready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", out_data, 'x);
                end else begin
                    check("out_word", out_data, exp_q.pop_front());
                end
            end
            hold_prev = out_v && !rready;
            hold_data = out_data;
        end
    end

    // Checks registered status against the model, then drives one cycle.
    task automatic step(input bit v, input logic [W-1:0] d, input bit r);
        bit pop_m, push_m;
        check("count", W'(count), W'(m_count));
        check("out_v", W'(out_v), W'(m_count != 0));
        check("full", W'(full), W'(m_count == DEPTH));
`ifdef MVAU_OUT_OVF_DET_EN
        check("ovf", W'(ovf), W'(m_ovf));
`endif
        in_v    = v;
        in_data = d;
        rready  = r;
        pop_m  = (m_count != 0) && r;
        push_m = v && ((m_count < DEPTH) || pop_m);
        if (push_m) exp_q.push_back(d);
        if (v && !push_m) m_ovf = 1'b1;
        #1;
        check("wait_rready", W'(wait_rready), W'((m_count != 0) && !r));
        m_count = m_count + int'(push_m) - int'(pop_m);
        @(posedge clk);
        #1;
    endtask

    // Reset for two cycles with in_v asserted; all stored words are discarded.
    task automatic do_reset();
        areset  = 1'b1;
        in_v    = 1'b1;
        in_data = 32'hDEAD_BEEF;
        rready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        areset = 1'b0;
        in_v   = 1'b0;
        exp_q.delete();
        m_count = 0;
        m_ovf   = 1'b0;
    endtask

    initial begin
        areset  = 1'b1;
        in_v    = 1'b0;
        in_data = '0;
        rready  = 1'b0;
        @(posedge clk);
        #1;

        // Reset with in_v held high.
        do_reset();
        check("reset_out_data", out_data, '0);
        step(1'b0, '0, 1'b0);

        // Latency: word appears next cycle and is popped immediately.
        step(1'b1, 32'h0003_FFFE, 1'b1);
        check("latency_data", out_data, 32'h0003_FFFE);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);

        // Backpressure: fill, hold, then drain in order.
        step(1'b1, 32'hA, 1'b0);
        step(1'b1, 32'hB, 1'b0);
        check("bp_head", out_data, 32'hA);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Push and pop while full, ten cycles around the pointer ring.
        step(1'b1, 32'h1, 1'b0);
        step(1'b1, 32'h2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'(i + 3), 1'b1);
        end
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Overflow: push into a full, stalled FIFO is dropped.
        step(1'b1, 32'h7, 1'b0);
        step(1'b1, 32'h8, 1'b0);
        step(1'b1, 32'h9, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Reset mid-stream: the stored word must never be emitted.
        do_reset();
        step(1'b1, 32'h55, 1'b0);
        do_reset();
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);

        // Randomized traffic with occasional overflow attempts.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0);
        end

        // Drain and confirm nothing is left outstanding.
        repeat (4) step(1'b0, '0, 1'b1);
        check("drained", W'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
